bit_serializer: RTL and testbench
=================================

Name: bit_serializer

Overview:
- Parallel-to-serial front end for the sequence detector stage. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clk on ser_out.
- ser_out connects directly to the detector's serial input `in`. ser_valid, ser_last and busy are for the bench and for downstream framing.
- A one-word holding register allows back-to-back words with no bubble.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- GAP, 0, number of idle cycles inserted after each word (ser_out=0, ser_valid=0); legal range 0..255.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  reset, synchronous, active-high.
- load_valid  input  1  load_data is offered this cycle.
- load_ready  output  1  hold register can accept a word.
- load_data  input  WIDTH  word to serialize.
- ser_out  output  1  serial bit to the detector; registered.
- ser_valid  output  1  ser_out carries a data bit; registered.
- ser_last  output  1  ser_out carries the final bit of a word; registered.
- busy  output  1  high in SHIFT or GAP, or when the hold register is full.

Behaviour:
- Reset behaviour (a registered reset edge): state=IDLE; ser_out, ser_valid and ser_last = 0; hold register empty; bit counter and gap counter cleared.
- load_ready = !hold_full && !reset. It is combinational and is 0 in any cycle where reset is high.
- Accept: a word is accepted on an edge where load_valid && load_ready. load_data is captured into the hold register and hold_full is set.
- The hold register is never written and drained on the same edge. While hold_full=1, load_ready=0.
- FSM states: IDLE, SHIFT, GAP.
- IDLE, hold_full=0: ser_out, ser_valid and ser_last are driven 0; remain in IDLE.
- IDLE, hold_full=1: on the next edge, transfer hold into the shift register and clear hold_full. On that same edge, ser_out takes the first bit and ser_valid=1; bitcnt=WIDTH-1; go to SHIFT.
- Latency: a word accepted at edge N presents its first bit in the cycle following edge N+1. Bits then appear on WIDTH consecutive cycles.
- Bit order: MSB first by default.
- SHIFT, bitcnt>0: on each edge, shift, present the next bit and decrement bitcnt. ser_last=1 when the bit being presented is the final one (bitcnt reaches 0).
- SHIFT, bitcnt=0 (final bit on ser_out), next edge:
  - GAP=0 and hold_full=1: load the next word immediately. No bubble; ser_valid stays 1; remain in SHIFT.
  - GAP>0: go to GAP with gapcnt=GAP-1; ser_out, ser_valid and ser_last = 0.
  - Otherwise: go to IDLE; outputs 0.
- GAP: outputs held 0. Decrement gapcnt each edge. When gapcnt=0, the next edge does the following:
  - hold_full=1: load the next word (SHIFT, first bit presented).
  - Otherwise: go to IDLE.
- Words can be accepted in any state while hold_full=0, including during SHIFT and GAP.
- Reset mid-word or mid-gap: the word in progress and the hold contents are discarded. Outputs are 0 after the reset edge. The next accepted word starts fresh from its first bit.
- ser_out is 0 whenever ser_valid=0. The detector therefore sees 0s between words, which returns it to its start state.
- busy = (state!=IDLE) || hold_full.

Optional Feature:
- Macro: BIT_SERIALIZER_LSB_FIRST_EN.
- Defined: bits are shifted out LSB first (load_data[0] first, load_data[WIDTH-1] last).
- Undefined: MSB first (load_data[WIDTH-1] first).
- Timing and handshake are identical in both cases.

Test Plan:
- Reset check: hold reset high 3 cycles with load_valid=1 -> load_ready=0 throughout, nothing is accepted, and all outputs are 0. After release, load_ready=1 and busy=0.
- Single word, WIDTH=8, GAP=0: 8'b1101_0000 accepted at edge N -> ser_out=1,1,0,1,0,0,0,0 on the cycles after edges N+1..N+8, with ser_valid=1 on those cycles. ser_last=1 only on the final 0; then IDLE with outputs 0. A detector attached downstream asserts out after the 4th bit.
- Back-to-back words: hold load_valid=1 with 8'hD5 then 8'h3C -> 16 contiguous ser_valid cycles with no bubble, ser_out=11010101_00111100. load_ready drops while hold is full and rises after each transfer.
- GAP=3: two words 8'hFF and 8'h01 offered back-to-back -> after the 8th bit of the first word, exactly 3 cycles with ser_valid=0 and ser_out=0, then 00000001.
- Reset mid-word: 8'hB4 in progress and 8'hFF in hold; assert reset on the cycle showing bit 4 -> outputs 0 after the reset edge and hold is empty. A new 8'h80 then serializes 1,0,0,0,0,0,0,0.
- With BIT_SERIALIZER_LSB_FIRST_EN defined: 8'hB0 -> ser_out=0,0,0,0,1,1,0,1, with ser_last on the final 1.

Source files
------------

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per clk out.
// Optional macro BIT_SERIALIZER_LSB_FIRST_EN selects LSB-first order (default MSB-first).
module bit_serializer #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int                CNT_W  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  BIT_LD = CNT_W'(WIDTH - 1);
  localparam logic [7:0]        GAP_LD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_hold_full;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [CNT_W-1:0] r_bitcnt, w_bitcnt_nxt;
  logic [7:0]       r_gapcnt, w_gapcnt_nxt;
  logic             r_ser_out, w_ser_out_nxt;
  logic             r_ser_valid, w_ser_valid_nxt;
  logic             r_ser_last, w_ser_last_nxt;
  logic             w_accept;
  logic             w_drain;

`ifdef BIT_SERIALIZER_LSB_FIRST_EN
  function automatic logic lead_bit(input logic [WIDTH-1:0] word);
    return word[0];
  endfunction
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] word);
    return word >> 1;
  endfunction
`else
  function automatic logic lead_bit(input logic [WIDTH-1:0] word);
    return word[WIDTH-1];
  endfunction
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] word);
    return word << 1;
  endfunction
`endif

  assign load_ready = !r_hold_full && !reset;
  assign w_accept   = load_valid && load_ready;
  assign busy       = (r_state != S_IDLE) || r_hold_full;
  assign ser_out    = r_ser_out;
  assign ser_valid  = r_ser_valid;
  assign ser_last   = r_ser_last;

  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_bitcnt_nxt    = r_bitcnt;
    w_gapcnt_nxt    = r_gapcnt;
    w_ser_out_nxt   = 1'b0;
    w_ser_valid_nxt = 1'b0;
    w_ser_last_nxt  = 1'b0;
    w_drain         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_hold_full) w_drain = 1'b1;
      end
      S_SHIFT: begin
        if (r_bitcnt != '0) begin
          w_ser_out_nxt   = lead_bit(r_shift);
          w_ser_valid_nxt = 1'b1;
          w_ser_last_nxt  = (r_bitcnt == CNT_W'(1));
          w_shift_nxt     = advance(r_shift);
          w_bitcnt_nxt    = r_bitcnt - CNT_W'(1);
        end else if (GAP == 0 && r_hold_full) begin
          w_drain = 1'b1;
        end else if (GAP > 0) begin
          w_state_nxt  = S_GAP;
          w_gapcnt_nxt = GAP_LD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        if (r_gapcnt != 8'd0) begin
          w_gapcnt_nxt = r_gapcnt - 8'd1;
        end else if (r_hold_full) begin
          w_drain = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A drain moves the hold word into the shifter and presents its first bit on the same edge.
    if (w_drain) begin
      w_state_nxt     = S_SHIFT;
      w_shift_nxt     = advance(r_hold);
      w_ser_out_nxt   = lead_bit(r_hold);
      w_ser_valid_nxt = 1'b1;
      w_ser_last_nxt  = 1'b0;
      w_bitcnt_nxt    = BIT_LD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_hold_full <= 1'b0;
      r_bitcnt    <= '0;
      r_gapcnt    <= 8'd0;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_ser_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bitcnt    <= w_bitcnt_nxt;
      r_gapcnt    <= w_gapcnt_nxt;
      r_ser_out   <= w_ser_out_nxt;
      r_ser_valid <= w_ser_valid_nxt;
      r_ser_last  <= w_ser_last_nxt;
      if (w_drain)       r_hold_full <= 1'b0;
      else if (w_accept) r_hold_full <= 1'b1;
    end
  end

  // Data path carries no reset; the control state decides when its contents matter.
  always_ff @(posedge clk) begin
    r_shift <= w_shift_nxt;
    if (w_accept) r_hold <= load_data;
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: a GAP=0 and a GAP=3 instance, bit stream checked against a queue.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       lv0, lv3;
  logic [7:0] ld0, ld3;
  logic       rdy0, so0, sv0, sl0, busy0;
  logic       rdy3, so3, sv3, sl3, busy3;

  int total = 0;
  int bad   = 0;

  logic [1:0] q0[$];
  logic [1:0] q3[$];

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .GAP(0)) u_dut0 (
    .clk(clk), .reset(reset), .load_valid(lv0), .load_ready(rdy0), .load_data(ld0),
    .ser_out(so0), .ser_valid(sv0), .ser_last(sl0), .busy(busy0)
  );

  bit_serializer #(.WIDTH(8), .GAP(3)) u_dut3 (
    .clk(clk), .reset(reset), .load_valid(lv3), .load_ready(rdy3), .load_data(ld3),
    .ser_out(so3), .ser_valid(sv3), .ser_last(sl3), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected bit stream of one word, entries are {last, bit}.
  task automatic push_word(input bit sel3, input logic [7:0] d);
    logic [1:0] e;
    for (int k = 0; k < 8; k++) begin
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
      e = {(k == 7), d[k]};
`else
      e = {(k == 7), d[7-k]};
`endif
      if (sel3) q3.push_back(e);
      else      q0.push_back(e);
    end
  endtask

  task automatic check_stream();
    logic [1:0] e;
    if (sv0) begin
      if (q0.size() == 0) chk("sb0_unexpected_bit", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        chk("ser_out0", so0, e[0]);
        chk("ser_last0", sl0, e[1]);
      end
    end else begin
      chk("idle_out0", so0, 1'b0);
      chk("idle_last0", sl0, 1'b0);
    end
    if (sv3) begin
      if (q3.size() == 0) chk("sb3_unexpected_bit", 32'd1, 32'd0);
      else begin
        e = q3.pop_front();
        chk("ser_out3", so3, e[0]);
        chk("ser_last3", sl3, e[1]);
      end
    end else begin
      chk("idle_out3", so3, 1'b0);
      chk("idle_last3", sl3, 1'b0);
    end
  endtask

  // One clock: note handshakes before the edge, score outputs 1ns after it.
  task automatic cyc();
    logic       a0, a3;
    logic [7:0] d0, d3;
    a0 = lv0 && rdy0;
    a3 = lv3 && rdy3;
    d0 = ld0;
    d3 = ld3;
    @(posedge clk);
    #1;
    if (a0) push_word(1'b0, d0);
    if (a3) push_word(1'b1, d3);
    check_stream();
  endtask

  task automatic single_word0(input logic [7:0] d, input string tag);
    lv0 = 1'b1; ld0 = d; #1;
    chk({tag, "_ready"}, rdy0, 1'b1);
    cyc();
    lv0 = 1'b0;
    chk({tag, "_lat"}, sv0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk({tag, "_valid"}, sv0, 1'b1);
    end
    cyc();
    chk({tag, "_end_valid"}, sv0, 1'b0);
    chk({tag, "_end_busy"}, busy0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    lv0 = 1'b1; ld0 = 8'hAA;
    lv3 = 1'b1; ld3 = 8'hAA;

    // Reset held three cycles while offering words.
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rst_ready0", rdy0, 1'b0);
      chk("rst_ready3", rdy3, 1'b0);
      cyc();
      chk("rst_valid0", sv0, 1'b0);
      chk("rst_busy0", busy0, 1'b0);
      chk("rst_valid3", sv3, 1'b0);
    end
    reset = 1'b0; lv0 = 1'b0; lv3 = 1'b0;
    #1;
    chk("post_rst_ready0", rdy0, 1'b1);
    chk("post_rst_busy0", busy0, 1'b0);
    chk("post_rst_ready3", rdy3, 1'b1);
    chk("post_rst_busy3", busy3, 1'b0);
    cyc();

    // Single word.
    single_word0(8'hD0, "single_d0");

    // Back-to-back words with no bubble.
    lv0 = 1'b1; ld0 = 8'hD5;
    cyc();
    ld0 = 8'h3C;
    chk("b2b_ready_full", rdy0, 1'b0);
    chk("b2b_busy_full", busy0, 1'b1);
    cyc();
    chk("b2b_ready_rise", rdy0, 1'b1);
    chk("b2b_first_valid", sv0, 1'b1);
    cyc();
    lv0 = 1'b0;
    chk("b2b_ready_drop", rdy0, 1'b0);
    chk("b2b_valid", sv0, 1'b1);
    for (int k = 2; k < 16; k++) begin
      cyc();
      chk("b2b_valid", sv0, 1'b1);
      if (k == 8) chk("b2b_ready_rise2", rdy0, 1'b1);
    end
    cyc();
    chk("b2b_end_valid", sv0, 1'b0);
    chk("b2b_end_busy", busy0, 1'b0);

    // GAP=3 instance: FF then 01 offered back-to-back.
    lv3 = 1'b1; ld3 = 8'hFF;
    cyc();
    ld3 = 8'h01;
    chk("gap_ready_full", rdy3, 1'b0);
    cyc();
    chk("gap_ready_rise", rdy3, 1'b1);
    cyc();
    lv3 = 1'b0;
    for (int k = 2; k < 8; k++) cyc();
    chk("gap_last_w1", sl3, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("gap_idle_valid", sv3, 1'b0);
      chk("gap_idle_out", so3, 1'b0);
      chk("gap_idle_busy", busy3, 1'b1);
    end
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("gap_w2_valid", sv3, 1'b1);
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("gap_trail_valid", sv3, 1'b0);
    end
    cyc();
    chk("gap_end_busy", busy3, 1'b0);

    // Reset in the middle of a word with another word in the hold register.
    lv0 = 1'b1; ld0 = 8'hB4;
    cyc();
    ld0 = 8'hFF;
    cyc();
    cyc();
    lv0 = 1'b0;
    chk("rmid_busy_full", busy0, 1'b1);
    cyc();
    cyc();
    reset = 1'b1;
    q0.delete();
    #1;
    chk("rmid_ready_in_reset", rdy0, 1'b0);
    cyc();
    chk("rmid_valid", sv0, 1'b0);
    chk("rmid_out", so0, 1'b0);
    chk("rmid_busy", busy0, 1'b0);
    reset = 1'b0;
    #1;
    chk("rmid_ready_after", rdy0, 1'b1);
    single_word0(8'h80, "after_rst_80");

    // Order-sensitive word for the bit-order option.
    single_word0(8'hB0, "order_b0");

    chk("q0_drained", q0.size(), 32'd0);
    chk("q3_drained", q3.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
